demux4_hs: RTL and testbench
============================

Name: demux4_hs

Overview:
- 1-to-4 demultiplexer with registered, handshaked outputs; the distribution counterpart of the 4-to-1 mux.
- Routes one input data stream to one of four destination channels selected by SEL, for example ALU result to register-file write ports or peripheral buses.
- Each output channel has a one-entry holding register with VALID/READY flow control, so a stalled destination blocks only transfers aimed at it.

Parameters:
- DATA_WIDTH, 8, width of the data path.
- CNT_WIDTH, 8, width of each per-channel transfer counter (optional feature only).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- IN  input  DATA_WIDTH  input data word.
- IN_VALID  input  1  IN and SEL are valid this cycle.
- IN_READY  output  1  block accepts the word this cycle.
- SEL  input  2  destination channel: 00 selects OUT0, 01 OUT1, 10 OUT2, 11 OUT3.
- OUT0..OUT3  output  DATA_WIDTH each  registered channel data.
- OUT0_VALID..OUT3_VALID  output  1 each  channel holds a word.
- OUT0_READY..OUT3_READY  input  1 each  destination consumes the word this cycle.
- CNT_ALL  output  4*CNT_WIDTH  present only with DEMUX4_CNT_EN; channel n counter at bits [n*CNT_WIDTH +: CNT_WIDTH].

Behaviour:
- Reset, while RST is high and asynchronously on assertion:
  - all OUTn = 0, all OUTn_VALID = 0, counters = 0.
  - IN_READY = 0 while RST is high.
- Handshake definitions:
  - Transfer into channel n occurs when IN_VALID & IN_READY & SEL==n at a clock edge.
  - Drain of channel n occurs when OUTn_VALID & OUTn_READY at a clock edge.
- IN_READY is combinational: IN_READY = ~RST & (~OUTs_VALID | OUTs_READY), where s = SEL.
  - It depends only on the selected channel.
  - A full channel that drains in the same cycle accepts a new word (pass-through, no bubble).
- Latency: a word accepted at edge k appears on OUTn with OUTn_VALID=1 after edge k, i.e. one cycle.
- Per-channel next state:
  - transfer (with or without drain): OUTn <= IN, OUTn_VALID <= 1.
  - drain without transfer: OUTn_VALID <= 0; OUTn keeps its last value.
  - otherwise: hold.
- OUTn and OUTn_VALID are stable while OUTn_VALID=1 and OUTn_READY=0.
- Independence: all four channels may drain in the same cycle. Only one channel can be written per cycle.
- SEL is not committed before the transfer.
  - While IN_VALID=1 and IN_READY=0 the source must hold IN/SEL.
  - If SEL changes anyway, IN_READY re-evaluates against the new channel. No error is flagged.
- IN_VALID=0: no channel is written, regardless of SEL or READY values.
- Reset mid-operation: held words are discarded, all VALIDs drop immediately, and counters clear.
- No internal FSM beyond the four VALID flags. Each channel is an EMPTY/FULL two-state machine:
  - EMPTY to FULL on transfer.
  - FULL to EMPTY on drain without transfer.
  - FULL to FULL on drain with transfer, or on hold.

Optional Feature:
- Macro: DEMUX4_CNT_EN.
- With the macro defined:
  - Four CNT_WIDTH counters; counter n increments by 1 on each transfer into channel n.
  - Counters wrap modulo 2^CNT_WIDTH (255 -> 0 at default width).
  - Counters clear only on RST.
  - Counters are exposed on CNT_ALL.
- Without the macro: no counters and no CNT_ALL port. Datapath behaviour is identical.

Test Plan:
- Reset: assert RST mid-stream with OUT2_VALID=1 -> all VALIDs 0 and all OUTn 0 immediately (before the next edge); IN_READY=0 until RST falls.
- Basic routing: IN=8'hA5, SEL=10, IN_VALID=1, all READY=0 -> after one edge OUT2=A5, OUT2_VALID=1, other VALIDs 0. Next cycle SEL=10: IN_READY=0. SEL=01: IN_READY=1.
- Backpressure hold: OUT1 full with 8'h3C, OUT1_READY=0 for 5 cycles -> OUT1 stays 3C with VALID=1 throughout. Then OUT1_READY=1 with IN_VALID=0 -> OUT1_VALID=0 after that edge.
- Pass-through: OUT3 full with 8'h11, OUT3_READY=1, IN=8'h22, SEL=11, IN_VALID=1 -> IN_READY=1; after the edge OUT3=22, OUT3_VALID=1, with no empty cycle.
- Parallel drain: all four channels full, all READY=1, IN_VALID=0 -> all VALIDs 0 after one edge. Random stress over 1000 cycles: every accepted word appears exactly once, in order per channel, checked with a scoreboard.
- DEMUX4_CNT_EN: 257 transfers into channel 0 -> CNT_ALL[7:0]=1; other counters 0; RST -> all 0.

Source files
------------

// File: rtl/demux4_hs.sv
// 1-to-4 handshaked demultiplexer with a one-entry register per channel.
// Define DEMUX4_CNT_EN to add per-channel transfer counters on CNT_ALL.
module demux4_hs #(
  parameter int DATA_WIDTH = 8
`ifdef DEMUX4_CNT_EN
  ,
  parameter int CNT_WIDTH  = 8
`endif
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [1:0]            SEL,
  output logic [DATA_WIDTH-1:0] OUT0,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2,
  output logic [DATA_WIDTH-1:0] OUT3,
  output logic                  OUT0_VALID,
  output logic                  OUT1_VALID,
  output logic                  OUT2_VALID,
  output logic                  OUT3_VALID,
  input  logic                  OUT0_READY,
  input  logic                  OUT1_READY,
  input  logic                  OUT2_READY,
  input  logic                  OUT3_READY
`ifdef DEMUX4_CNT_EN
  ,
  output logic [4*CNT_WIDTH-1:0] CNT_ALL
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  ch_state_e             st_q   [4];
  ch_state_e             st_d   [4];
  logic [DATA_WIDTH-1:0] data_q [4];
  logic [DATA_WIDTH-1:0] data_d [4];

  logic [3:0] out_ready;
  logic [3:0] wr_en;
  logic [3:0] drain;
  logic       in_ready;

  assign out_ready = {OUT3_READY, OUT2_READY,
                      OUT1_READY, OUT0_READY};

  // Acceptance looks only at the selected channel; a draining
  // full channel still accepts, giving pass-through without a bubble.
  always_comb begin
    in_ready = ~RST & ((st_q[SEL] == EMPTY) | out_ready[SEL]);
    wr_en    = '0;
    for (int n = 0; n < 4; n++) begin
      wr_en[n] = IN_VALID & in_ready & (SEL == 2'(n));
    end
  end

  // A channel drains whenever it holds a word and its sink is ready.
  always_comb begin
    drain = '0;
    for (int n = 0; n < 4; n++) begin
      drain[n] = (st_q[n] == FULL) & out_ready[n];
    end
  end

  // Per-channel EMPTY/FULL next state; a write wins over a drain.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      st_d[n]   = st_q[n];
      data_d[n] = data_q[n];
      unique case (1'b1)
        wr_en[n]: begin
          st_d[n]   = FULL;
          data_d[n] = IN;
        end
        drain[n] & ~wr_en[n]: begin
          st_d[n] = EMPTY;
        end
        default: ;
      endcase
    end
  end

  // Channel registers; reset discards held words immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int n = 0; n < 4; n++) begin
        st_q[n]   <= EMPTY;
        data_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        st_q[n]   <= st_d[n];
        data_q[n] <= data_d[n];
      end
    end
  end

  assign IN_READY   = in_ready;
  assign OUT0       = data_q[0];
  assign OUT1       = data_q[1];
  assign OUT2       = data_q[2];
  assign OUT3       = data_q[3];
  assign OUT0_VALID = (st_q[0] == FULL);
  assign OUT1_VALID = (st_q[1] == FULL);
  assign OUT2_VALID = (st_q[2] == FULL);
  assign OUT3_VALID = (st_q[3] == FULL);

`ifdef DEMUX4_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q [4];
  logic [CNT_WIDTH-1:0] cnt_d [4];

  // Count transfers per channel; wraps naturally at 2^CNT_WIDTH.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      cnt_d[n] = cnt_q[n];
      if (wr_en[n]) begin
        cnt_d[n] = cnt_q[n] + CNT_WIDTH'(1);
      end
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int n = 0; n < 4; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  // Pack the four counters, channel n at slice n.
  always_comb begin
    CNT_ALL = '0;
    for (int n = 0; n < 4; n++) begin
      CNT_ALL[n*CNT_WIDTH +: CNT_WIDTH] = cnt_q[n];
    end
  end
`endif

endmodule

// File: tb/tb_demux4_hs.sv
// Directed and scoreboard bench for demux4_hs.
// Counter checks are compiled in when DEMUX4_CNT_EN is defined.
module tb_demux4_hs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_d = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] sel = '0;
  logic [3:0] rdy = '0;
  logic [7:0] out0, out1, out2, out3;
  logic       v0, v1, v2, v3;
  logic [3:0] vld;
  logic [7:0] outd [4];
`ifdef DEMUX4_CNT_EN
  logic [31:0] cnt_all;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sb [4][$];

  always #5 clk = ~clk;

  assign vld = {v3, v2, v1, v0};
  assign outd[0] = out0;
  assign outd[1] = out1;
  assign outd[2] = out2;
  assign outd[3] = out3;

  demux4_hs dut (
    .CLK(clk),
    .RST(rst),
    .IN(in_d),
    .IN_VALID(in_valid),
    .IN_READY(in_ready),
    .SEL(sel),
    .OUT0(out0),
    .OUT1(out1),
    .OUT2(out2),
    .OUT3(out3),
    .OUT0_VALID(v0),
    .OUT1_VALID(v1),
    .OUT2_VALID(v2),
    .OUT3_VALID(v3),
    .OUT0_READY(rdy[0]),
    .OUT1_READY(rdy[1]),
    .OUT2_READY(rdy[2]),
    .OUT3_READY(rdy[3])
`ifdef DEMUX4_CNT_EN
    ,
    .CNT_ALL(cnt_all)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_cycle(input logic       v,
                          input logic [1:0] s,
                          input logic [7:0] d,
                          input logic [3:0] r);
    logic       exp_rdy;
    logic [3:0] exp_vld;
    in_valid = v;
    sel      = s;
    in_d     = d;
    rdy      = r;
    #1;
    for (int n = 0; n < 4; n++) begin
      exp_vld[n] = (sb[n].size() != 0);
    end
    check("sb_valid", 32'(vld), 32'(exp_vld));
    exp_rdy = (sb[s].size() == 0) | r[s];
    check("sb_in_ready", 32'(in_ready), 32'(exp_rdy));
    for (int n = 0; n < 4; n++) begin
      if (exp_vld[n] & r[n]) begin
        check("sb_data", 32'(outd[n]), 32'(sb[n][0]));
        void'(sb[n].pop_front());
      end
    end
    if (v & exp_rdy) begin
      sb[s].push_back(d);
    end
    step();
  endtask

  initial begin
    // reset state
    in_valid = 1'b1;
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(vld), 32'd0);
    check("rst_out0", 32'(out0), 32'd0);
    check("rst_out3", 32'(out3), 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_rel_ready", 32'(in_ready), 32'd1);

    // basic routing
    in_d = 8'hA5;
    sel = 2'd2;
    in_valid = 1'b1;
    step();
    check("route_out2", 32'(out2), 32'hA5);
    check("route_valid", 32'(vld), 32'b0100);
    #1;
    check("route_rdy_full", 32'(in_ready), 32'd0);
    sel = 2'd1;
    in_d = 8'h3C;
    #1;
    check("route_rdy_other", 32'(in_ready), 32'd1);

    // backpressure hold on channel 1
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_out1", 32'(out1), 32'h3C);
      check("hold_v1", 32'(v1), 32'd1);
    end
    rdy[1] = 1'b1;
    step();
    rdy[1] = 1'b0;
    check("drain_v1", 32'(v1), 32'd0);
    check("drain_out1", 32'(out1), 32'h3C);

    // pass-through on channel 3
    sel = 2'd3;
    in_d = 8'h11;
    in_valid = 1'b1;
    step();
    check("pt_load", 32'(out3), 32'h11);
    rdy[3] = 1'b1;
    in_d = 8'h22;
    #1;
    check("pt_in_ready", 32'(in_ready), 32'd1);
    step();
    check("pt_out3", 32'(out3), 32'h22);
    check("pt_v3", 32'(v3), 32'd1);

    // IN_VALID low writes nothing
    in_valid = 1'b0;
    rdy[3] = 1'b0;
    sel = 2'd0;
    rdy[0] = 1'b1;
    step();
    check("novalid_vld", 32'(vld), 32'b1100);
    rdy[0] = 1'b0;

    // asynchronous reset mid-stream
    #2;
    rst = 1'b1;
    in_valid = 1'b1;
    #1;
    check("arst_valid", 32'(vld), 32'd0);
    check("arst_out2", 32'(out2), 32'd0);
    check("arst_out3", 32'(out3), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    step();
    check("arst_hold_rdy", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("arst_rel_rdy", 32'(in_ready), 32'd1);

    // parallel drain of all four channels
    for (int s = 0; s < 4; s++) begin
      in_valid = 1'b1;
      sel = 2'(s);
      in_d = 8'h40 + 8'(s);
      step();
    end
    in_valid = 1'b0;
    check("par_full", 32'(vld), 32'hF);
    check("par_out0", 32'(out0), 32'h40);
    check("par_out3", 32'(out3), 32'h43);
    rdy = 4'hF;
    step();
    check("par_empty", 32'(vld), 32'd0);
    rdy = 4'h0;

    // random stress with scoreboard
    for (int i = 0; i < 1000; i++) begin
      sb_cycle(1'($urandom_range(0, 3) != 0),
               2'($urandom_range(0, 3)),
               8'($urandom),
               4'($urandom));
    end
    for (int i = 0; i < 3; i++) begin
      sb_cycle(1'b0, 2'd0, 8'd0, 4'hF);
    end
    check("sb_left",
          sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size(),
          32'd0);
    check("sb_end_vld", 32'(vld), 32'd0);

`ifdef DEMUX4_CNT_EN
    // counter wrap on channel 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    sel = 2'd0;
    rdy = 4'b0001;
    in_valid = 1'b1;
    for (int i = 0; i < 257; i++) begin
      in_d = 8'(i);
      step();
    end
    in_valid = 1'b0;
    check("cnt0_wrap", 32'(cnt_all[7:0]), 32'd1);
    check("cnt_others", 32'(cnt_all[31:8]), 32'd0);
    rst = 1'b1;
    #1;
    check("cnt_rst", cnt_all, 32'd0);
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
